// File: rtl/adder_mw_seq.sv
// Multi-word add/sub sequencer driving one external WIDTH-bit adder.
// Slices operands LS word first, chains the carry and assembles the result.
module adder_mw_seq #(
  parameter int WIDTH = 32,
  parameter int WORDS = 4,
  parameter int LW    = $clog2(WORDS) + 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_req_valid,
  output logic                   o_req_ready,
  input  logic                   i_req_sub,
  input  logic [LW-1:0]          i_req_len,
  input  logic [WIDTH*WORDS-1:0] i_req_a,
  input  logic [WIDTH*WORDS-1:0] i_req_b,
  output logic [WIDTH-1:0]       o_add_a,
  output logic [WIDTH-1:0]       o_add_b,
  output logic                   o_add_c,
  input  logic [WIDTH-1:0]       i_add_sum,
  input  logic                   i_add_carry,
  output logic                   o_res_valid,
  input  logic                   i_res_ready,
  output logic [WIDTH*WORDS-1:0] o_res,
  output logic                   o_res_carry,
  output logic                   o_busy
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [WIDTH*WORDS-1:0] a_q;
  logic [WIDTH*WORDS-1:0] b_q;
  logic [WIDTH*WORDS-1:0] res_q;
  logic                   sub_q;
  logic                   carry_q;
  logic                   res_carry_q;
  logic [LW-1:0]          idx_q;
  logic [LW-1:0]          len_q;
  logic [LW-1:0]          len_eff;
  logic                   accept;
  logic                   last;
  logic [WIDTH-1:0]       a_sel;
  logic [WIDTH-1:0]       b_sel;

  // Zero or oversized length requests mean the full operand width.
  always_comb begin
    len_eff = i_req_len;
    if (i_req_len == '0 || i_req_len > LW'(WORDS)) begin
      len_eff = LW'(WORDS);
    end
  end

  assign last = (idx_q == len_q - LW'(1));

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state and handshake outputs.
  always_comb begin
    state_nx    = state;
    o_req_ready = 1'b0;
    o_res_valid = 1'b0;
    o_busy      = 1'b0;
    accept      = 1'b0;
    unique case (state)
      IDLE: begin
        o_req_ready = ~i_rst;
        accept      = i_req_valid & ~i_rst;
        if (accept) begin
          state_nx = RUN;
        end
      end
      RUN: begin
        o_busy = 1'b1;
        if (last) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        o_busy      = 1'b1;
        o_res_valid = 1'b1;
        if (i_res_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Select the current word slice; adder inputs idle at zero outside RUN.
  always_comb begin
    a_sel   = '0;
    b_sel   = '0;
    o_add_a = '0;
    o_add_b = '0;
    o_add_c = 1'b0;
    for (int k = 0; k < WORDS; k++) begin
      if (idx_q == LW'(k)) begin
        a_sel = a_q[k*WIDTH +: WIDTH];
        b_sel = b_q[k*WIDTH +: WIDTH];
      end
    end
    if (state == RUN) begin
      o_add_a = a_sel;
      o_add_b = sub_q ? ~b_sel : b_sel;
      o_add_c = carry_q;
    end
  end

  // Operand capture, carry chaining and result assembly.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      sub_q       <= 1'b0;
      carry_q     <= 1'b0;
      res_carry_q <= 1'b0;
      idx_q       <= '0;
      len_q       <= '0;
    end else if (accept) begin
      a_q         <= i_req_a;
      b_q         <= i_req_b;
      res_q       <= '0;
      sub_q       <= i_req_sub;
      carry_q     <= i_req_sub;
      res_carry_q <= 1'b0;
      idx_q       <= '0;
      len_q       <= len_eff;
    end else if (state == RUN) begin
      for (int k = 0; k < WORDS; k++) begin
        if (idx_q == LW'(k)) begin
          res_q[k*WIDTH +: WIDTH] <= i_add_sum;
        end
      end
      carry_q <= i_add_carry;
      idx_q   <= idx_q + LW'(1);
      if (last) begin
        res_carry_q <= i_add_carry;
      end
    end
  end

  assign o_res       = res_q;
  assign o_res_carry = res_carry_q;

endmodule

// File: tb/tb_adder_mw_seq.sv
// Directed bench for adder_mw_seq with an external adder.
// Checks results, carry, latency, backpressure and reset abort.
module tb_adder_mw_seq;

  localparam int WIDTH = 32;
  localparam int WORDS = 4;
  localparam int LW    = $clog2(WORDS) + 1;

  logic                   clk;
  logic                   rst;
  logic                   req_valid;
  logic                   req_ready;
  logic                   req_sub;
  logic [LW-1:0]          req_len;
  logic [WIDTH*WORDS-1:0] req_a;
  logic [WIDTH*WORDS-1:0] req_b;
  logic [WIDTH-1:0]       add_a;
  logic [WIDTH-1:0]       add_b;
  logic                   add_c;
  logic [WIDTH-1:0]       add_sum;
  logic                   add_carry;
  logic                   res_valid;
  logic                   res_ready;
  logic [WIDTH*WORDS-1:0] res;
  logic                   res_carry;
  logic                   busy;

  int n_vec = 0;
  int n_err = 0;
  int lat;
  logic c_hist [0:15];
  logic [WIDTH*WORDS-1:0] hold;

  adder_mw_seq #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_sub   (req_sub),
    .i_req_len   (req_len),
    .i_req_a     (req_a),
    .i_req_b     (req_b),
    .o_add_a     (add_a),
    .o_add_b     (add_b),
    .o_add_c     (add_c),
    .i_add_sum   (add_sum),
    .i_add_carry (add_carry),
    .o_res_valid (res_valid),
    .i_res_ready (res_ready),
    .o_res       (res),
    .o_res_carry (res_carry),
    .o_busy      (busy)
  );

  assign {add_carry, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_c};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_op(input logic sub, input logic [LW-1:0] len,
                        input logic [127:0] a, input logic [127:0] b,
                        input int exp_lat);
    @(negedge clk);
    req_valid = 1'b1;
    req_sub   = sub;
    req_len   = len;
    req_a     = a;
    req_b     = b;
    chk("req_ready", 128'(req_ready), 128'(1));
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 0;
    while (!res_valid && lat < 16) begin
      c_hist[lat] = add_c;
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", 128'(lat), 128'(exp_lat));
    chk("busy_done", 128'(busy), 128'(1));
  endtask

  task automatic finish_res();
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    chk("valid_drop", 128'(res_valid), 128'(0));
    chk("ready_idle", 128'(req_ready), 128'(1));
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_sub   = 1'b0;
    req_len   = '0;
    req_a     = '0;
    req_b     = '0;
    res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_res", res, 128'(0));
    chk("rst_valid", 128'(res_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_add", {add_a, add_b, add_c}, 128'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_ready", 128'(req_ready), 128'(1));

    // 1-word add
    run_op(1'b0, 3'd1, 128'h5, 128'h3, 1);
    chk("add1_res", res, 128'h8);
    chk("add1_c", 128'(res_carry), 128'(0));
    finish_res();

    // 2-word add with carry across words; junk above len must not leak
    run_op(1'b0, 3'd2, 128'hDEADBEEF_CAFEF00D_00000000_FFFFFFFF,
           128'h11111111_22222222_00000000_00000001, 2);
    chk("add2_res", res, 128'h00000001_00000000);
    chk("add2_c", 128'(res_carry), 128'(0));
    chk("add2_cin0", 128'(c_hist[0]), 128'(0));
    chk("add2_cin1", 128'(c_hist[1]), 128'(1));
    finish_res();

    // 2-word sub with borrow
    run_op(1'b1, 3'd2, 128'h0, 128'h1, 2);
    chk("sub2_res", res, 128'hFFFFFFFF_FFFFFFFF);
    chk("sub2_c", 128'(res_carry), 128'(0));
    finish_res();

    // 2-word sub of equal operands
    run_op(1'b1, 3'd2, 128'h12345678_9ABCDEF0, 128'h12345678_9ABCDEF0, 2);
    chk("sube_res", res, 128'h0);
    chk("sube_c", 128'(res_carry), 128'(1));
    finish_res();

    // len=0 means all four words
    run_op(1'b0, 3'd0, {128{1'b1}}, 128'h1, 4);
    chk("len0_res", res, 128'h0);
    chk("len0_c", 128'(res_carry), 128'(1));
    finish_res();

    // len=7 clamps to four words
    run_op(1'b0, 3'd7, 128'h1_00000000_00000000_00000001,
           128'h2_00000000_00000000_00000002, 4);
    chk("len7_res", res, 128'h3_00000000_00000000_00000003);
    chk("len7_c", 128'(res_carry), 128'(0));
    finish_res();

    // 3-word sub across word boundaries
    run_op(1'b1, 3'd3, 128'h1_00000000_00000000, 128'h1, 3);
    chk("sub3_res", res, 128'h0_FFFFFFFF_FFFFFFFF);
    chk("sub3_c", 128'(res_carry), 128'(1));

    // Backpressure in DONE with a competing request held
    hold = 128'h0_FFFFFFFF_FFFFFFFF;
    @(negedge clk);
    req_valid = 1'b1;
    req_sub   = 1'b0;
    req_len   = 3'd1;
    req_a     = 128'h7;
    req_b     = 128'h7;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("bp_res", res, hold);
      chk("bp_ready", 128'(req_ready), 128'(0));
      chk("bp_valid", 128'(res_valid), 128'(1));
    end
    @(negedge clk);
    req_valid = 1'b0;
    finish_res();
    run_op(1'b0, 3'd1, 128'h7, 128'h7, 1);
    chk("bp_next", res, 128'hE);
    finish_res();

    // Reset in the 2nd RUN cycle of a 4-word op
    @(negedge clk);
    req_valid = 1'b1;
    req_sub   = 1'b0;
    req_len   = 3'd4;
    req_a     = {128{1'b1}};
    req_b     = 128'h1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_busy", 128'(busy), 128'(1));
    rst = 1'b1;
    #1;
    chk("abort_res", res, 128'h0);
    chk("abort_valid", 128'(res_valid), 128'(0));
    chk("abort_busy", 128'(busy), 128'(0));
    chk("abort_add", {add_a, add_b, add_c}, 128'(0));
    chk("abort_rc", 128'(res_carry), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_ready", 128'(req_ready), 128'(1));
    run_op(1'b0, 3'd1, 128'hFFFFFFFF, 128'h1, 1);
    chk("post_res", res, 128'h0);
    chk("post_c", 128'(res_carry), 128'(1));
    finish_res();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
